// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM burst port between two masters.
//   Master 0 is the instruction cache; master 1 is the data cache.
//   Only one read or write burst is in flight at a time. The granted
//   master's channels are routed to the RAM, and the other master sees
//   all-zero responses.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   m{0,1}_aw*/w*        master write address and write data channels
//   m{0,1}_ar*/r*        master read address and read data channels
//   ram_*                RAM-side copies of the granted master's channels
//   grant                one-hot owner (2'b00 when idle)
//   busy                 high whenever a burst owns the port
//   timeout              one-cycle pulse when an address phase is aborted
//
// Build option:
//   RAM_ARB_RR_EN  Round-robin arbitration between the two masters.
//                  When this macro is undefined, master 1 has fixed priority.
//
// Widths come from AWIDTH/LWIDTH/DWIDTH. These are normally set in
// param_ram.vh and fall back to the defaults below.
`ifndef AWIDTH
`define AWIDTH 32
`endif
`ifndef LWIDTH
`define LWIDTH 8
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module ram_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [`AWIDTH-1:0] m0_awaddr,
  input  logic [`LWIDTH-1:0] m0_awlen,
  input  logic               m0_awvalid,
  output logic               m0_awready,
  input  logic [`DWIDTH-1:0] m0_wdata,
  output logic               m0_wvalid,
  input  logic               m0_wready,
  output logic               m0_wlast,
  input  logic [`AWIDTH-1:0] m0_araddr,
  input  logic [`LWIDTH-1:0] m0_arlen,
  input  logic               m0_arvalid,
  output logic               m0_arready,
  output logic [`DWIDTH-1:0] m0_rdata,
  output logic               m0_rvalid,
  input  logic               m0_rready,
  output logic               m0_rlast,
  input  logic [`AWIDTH-1:0] m1_awaddr,
  input  logic [`LWIDTH-1:0] m1_awlen,
  input  logic               m1_awvalid,
  output logic               m1_awready,
  input  logic [`DWIDTH-1:0] m1_wdata,
  output logic               m1_wvalid,
  input  logic               m1_wready,
  output logic               m1_wlast,
  input  logic [`AWIDTH-1:0] m1_araddr,
  input  logic [`LWIDTH-1:0] m1_arlen,
  input  logic               m1_arvalid,
  output logic               m1_arready,
  output logic [`DWIDTH-1:0] m1_rdata,
  output logic               m1_rvalid,
  input  logic               m1_rready,
  output logic               m1_rlast,
  output logic [`AWIDTH-1:0] ram_awaddr,
  output logic [`LWIDTH-1:0] ram_awlen,
  output logic               ram_awvalid,
  input  logic               ram_awready,
  output logic [`DWIDTH-1:0] ram_wdata,
  input  logic               ram_wvalid,
  output logic               ram_wready,
  input  logic               ram_wlast,
  output logic [`AWIDTH-1:0] ram_araddr,
  output logic [`LWIDTH-1:0] ram_arlen,
  output logic               ram_arvalid,
  input  logic               ram_arready,
  input  logic [`DWIDTH-1:0] ram_rdata,
  input  logic               ram_rvalid,
  output logic               ram_rready,
  input  logic               ram_rlast,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA} state_t;

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYC - 1);

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant_r;
  logic [CW-1:0]          tcnt;

  logic rd_addr, rd_data, wr_addr, wr_data, g1;
  assign rd_addr = (state == RD_ADDR);
  assign rd_data = (state == RD_DATA);
  assign wr_addr = (state == WR_ADDR);
  assign wr_data = (state == WR_DATA);
  assign g1      = grant_r[1];
  assign grant   = grant_r;
  assign busy    = (state != IDLE);

  // Granted master's request signals. These are used both for routing and
  // for detecting that the master dropped its request.
  logic sel_arvalid, sel_awvalid;
  assign sel_arvalid = g1 ? m1_arvalid : m0_arvalid;
  assign sel_awvalid = g1 ? m1_awvalid : m0_awvalid;

  // RAM side: mux of the granted master. Each channel is live only in its phase.
  assign ram_arvalid = rd_addr & sel_arvalid;
  assign ram_araddr  = rd_addr ? (g1 ? m1_araddr : m0_araddr) : '0;
  assign ram_arlen   = rd_addr ? (g1 ? m1_arlen  : m0_arlen)  : '0;
  assign ram_awvalid = wr_addr & sel_awvalid;
  assign ram_awaddr  = wr_addr ? (g1 ? m1_awaddr : m0_awaddr) : '0;
  assign ram_awlen   = wr_addr ? (g1 ? m1_awlen  : m0_awlen)  : '0;
  assign ram_wdata   = wr_data ? (g1 ? m1_wdata  : m0_wdata)  : '0;
  assign ram_wready  = wr_data & (g1 ? m1_wready : m0_wready);
  assign ram_rready  = rd_data & (g1 ? m1_rready : m0_rready);

  // Master side: RAM responses reach only the owner. Everything else is zero.
  assign m0_arready = rd_addr & grant_r[0] & ram_arready;
  assign m1_arready = rd_addr & grant_r[1] & ram_arready;
  assign m0_awready = wr_addr & grant_r[0] & ram_awready;
  assign m1_awready = wr_addr & grant_r[1] & ram_awready;
  assign m0_wvalid  = wr_data & grant_r[0] & ram_wvalid;
  assign m1_wvalid  = wr_data & grant_r[1] & ram_wvalid;
  assign m0_wlast   = wr_data & grant_r[0] & ram_wlast;
  assign m1_wlast   = wr_data & grant_r[1] & ram_wlast;
  assign m0_rvalid  = rd_data & grant_r[0] & ram_rvalid;
  assign m1_rvalid  = rd_data & grant_r[1] & ram_rvalid;
  assign m0_rlast   = rd_data & grant_r[0] & ram_rlast;
  assign m1_rlast   = rd_data & grant_r[1] & ram_rlast;
  assign m0_rdata   = (rd_data & grant_r[0]) ? ram_rdata : '0;
  assign m1_rdata   = (rd_data & grant_r[1]) ? ram_rdata : '0;

  logic req0, req1, win1, win_aw;
  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;

`ifdef RAM_ARB_RR_EN
  // last1 records whether master 1 won the previous arbitration. It resets
  // to 0, so master 1 is preferred first. Grants then alternate under
  // sustained contention.
  logic last1;
  assign win1 = req1 & (~req0 | ~last1);
`else
  assign win1 = req1;
`endif
  // A pending write from the winner goes first, so a writeback precedes its refill.
  assign win_aw = win1 ? m1_awvalid : m0_awvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_r <= '0;
      tcnt    <= '0;
      timeout <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last1   <= 1'b0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant_r <= win1 ? 2'b10 : 2'b01;
            state   <= win_aw ? WR_ADDR : RD_ADDR;
            tcnt    <= '0;
`ifdef RAM_ARB_RR_EN
            last1   <= win1;
`endif
          end
        end
        RD_ADDR, WR_ADDR: begin
          if (rd_addr ? (ram_arvalid & ram_arready) : (ram_awvalid & ram_awready)) begin
            state <= rd_addr ? RD_DATA : WR_DATA;
            tcnt  <= '0;
          end else if (!(rd_addr ? sel_arvalid : sel_awvalid)) begin
            // The master withdrew its request. Release without any transfer.
            state   <= IDLE;
            grant_r <= '0;
            tcnt    <= '0;
          end else if (tcnt == TLIM) begin
            state   <= IDLE;
            grant_r <= '0;
            tcnt    <= '0;
            timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RD_DATA: begin
          if (ram_rvalid & ram_rready & ram_rlast) begin
            state   <= IDLE;
            grant_r <= '0;
          end
        end
        WR_DATA: begin
          if (ram_wvalid & ram_wready & ram_wlast) begin
            state   <= IDLE;
            grant_r <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_r <= '0;
          tcnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. A transaction-level model of ownership is
// checked against every DUT output on each falling edge. Directed scenarios
// add literal expectations for read, contention, write-before-read,
// backpressure, reset mid-burst and timeout.
`ifndef AWIDTH
`define AWIDTH 32
`endif
`ifndef LWIDTH
`define LWIDTH 8
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module tb_ram_arbiter;
  localparam int TO = 8;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] awvalid, wready, arvalid, rready;
  logic [`AWIDTH-1:0] awaddr [2];
  logic [`AWIDTH-1:0] araddr [2];
  logic [`LWIDTH-1:0] awlen [2];
  logic [`LWIDTH-1:0] arlen [2];
  logic [`DWIDTH-1:0] wdata [2];
  logic [1:0] awready_o, wvalid_o, wlast_o, arready_o, rvalid_o, rlast_o;
  logic [`DWIDTH-1:0] rdata_o [2];

  logic [`AWIDTH-1:0] ram_awaddr, ram_araddr;
  logic [`LWIDTH-1:0] ram_awlen, ram_arlen;
  logic [`DWIDTH-1:0] ram_wdata;
  logic ram_awvalid, ram_wready, ram_arvalid, ram_rready;
  logic r_awready, r_wvalid, r_wlast, r_arready, r_rvalid, r_rlast;
  logic [`DWIDTH-1:0] r_rdata;
  logic [1:0] grant;
  logic busy, timeout;

  ram_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_awaddr(awaddr[0]), .m0_awlen(awlen[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready_o[0]),
    .m0_wdata(wdata[0]), .m0_wvalid(wvalid_o[0]), .m0_wready(wready[0]), .m0_wlast(wlast_o[0]),
    .m0_araddr(araddr[0]), .m0_arlen(arlen[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready_o[0]),
    .m0_rdata(rdata_o[0]), .m0_rvalid(rvalid_o[0]), .m0_rready(rready[0]), .m0_rlast(rlast_o[0]),
    .m1_awaddr(awaddr[1]), .m1_awlen(awlen[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready_o[1]),
    .m1_wdata(wdata[1]), .m1_wvalid(wvalid_o[1]), .m1_wready(wready[1]), .m1_wlast(wlast_o[1]),
    .m1_araddr(araddr[1]), .m1_arlen(arlen[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready_o[1]),
    .m1_rdata(rdata_o[1]), .m1_rvalid(rvalid_o[1]), .m1_rready(rready[1]), .m1_rlast(rlast_o[1]),
    .ram_awaddr(ram_awaddr), .ram_awlen(ram_awlen), .ram_awvalid(ram_awvalid), .ram_awready(r_awready),
    .ram_wdata(ram_wdata), .ram_wvalid(r_wvalid), .ram_wready(ram_wready), .ram_wlast(r_wlast),
    .ram_araddr(ram_araddr), .ram_arlen(ram_arlen), .ram_arvalid(ram_arvalid), .ram_arready(r_arready),
    .ram_rdata(r_rdata), .ram_rvalid(r_rvalid), .ram_rready(ram_rready), .ram_rlast(r_rlast),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model. It tracks who owns the port, whether the burst
  // is a write, and whether the address has been accepted yet.
  int m_owner = -1;
  bit m_wr, m_addr, m_pulse;
  int m_wait;
  int m_pref = 1;

  always @(negedge clk) begin
    bit rd_a, rd_d, wr_a, wr_d, own, req, rdy, r0, r1;
    int o, w;
    if (!rst_n) begin
      m_owner = -1; m_pulse = 0; m_wait = 0; m_pref = 1;
    end
    o = (m_owner < 0) ? 0 : m_owner;
    rd_a = (m_owner >= 0) && !m_wr && m_addr;
    rd_d = (m_owner >= 0) && !m_wr && !m_addr;
    wr_a = (m_owner >= 0) && m_wr && m_addr;
    wr_d = (m_owner >= 0) && m_wr && !m_addr;
    chk("grant", grant, (m_owner < 0) ? 0 : (m_owner == 1 ? 2 : 1));
    chk("busy", busy, m_owner >= 0);
    chk("timeout", timeout, m_pulse);
    chk("ram_arvalid", ram_arvalid, rd_a ? arvalid[o] : 1'b0);
    chk("ram_araddr", ram_araddr, rd_a ? araddr[o] : '0);
    chk("ram_arlen", ram_arlen, rd_a ? arlen[o] : '0);
    chk("ram_awvalid", ram_awvalid, wr_a ? awvalid[o] : 1'b0);
    chk("ram_awaddr", ram_awaddr, wr_a ? awaddr[o] : '0);
    chk("ram_awlen", ram_awlen, wr_a ? awlen[o] : '0);
    chk("ram_wdata", ram_wdata, wr_d ? wdata[o] : '0);
    chk("ram_wready", ram_wready, wr_d ? wready[o] : 1'b0);
    chk("ram_rready", ram_rready, rd_d ? rready[o] : 1'b0);
    for (int i = 0; i < 2; i++) begin
      own = (m_owner == i);
      chk($sformatf("m%0d_arready", i), arready_o[i], (own && rd_a) ? r_arready : 1'b0);
      chk($sformatf("m%0d_awready", i), awready_o[i], (own && wr_a) ? r_awready : 1'b0);
      chk($sformatf("m%0d_wvalid", i), wvalid_o[i], (own && wr_d) ? r_wvalid : 1'b0);
      chk($sformatf("m%0d_wlast", i), wlast_o[i], (own && wr_d) ? r_wlast : 1'b0);
      chk($sformatf("m%0d_rvalid", i), rvalid_o[i], (own && rd_d) ? r_rvalid : 1'b0);
      chk($sformatf("m%0d_rlast", i), rlast_o[i], (own && rd_d) ? r_rlast : 1'b0);
      chk($sformatf("m%0d_rdata", i), rdata_o[i], (own && rd_d) ? r_rdata : '0);
    end
    // Advance the model to what must hold after the coming rising edge.
    if (rst_n) begin
      m_pulse = 0;
      if (m_owner < 0) begin
        r0 = arvalid[0] | awvalid[0];
        r1 = arvalid[1] | awvalid[1];
        if (r0 || r1) begin
          if (!r0) w = 1;
          else if (!r1) w = 0;
          else w = RR ? m_pref : 1;
          m_pref = 1 - w;
          m_owner = w; m_wr = awvalid[w]; m_addr = 1; m_wait = 0;
        end
      end else if (m_addr) begin
        req = m_wr ? awvalid[o] : arvalid[o];
        rdy = m_wr ? r_awready : r_arready;
        if (req && rdy) m_addr = 0;
        else if (!req) m_owner = -1;
        else if (m_wait == TO - 1) begin m_owner = -1; m_pulse = 1; end
        else m_wait++;
      end else begin
        if (m_wr ? (r_wvalid && wready[o] && r_wlast) : (r_rvalid && rready[o] && r_rlast))
          m_owner = -1;
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic bubble();
    @(negedge clk); chk("bubble_busy", busy, 0); chk("bubble_grant", grant, 0);
    next();
  endtask

  // Called in the RD_ADDR cycle for master `who`. Accepts the address, then
  // returns n beats of data d0, d0+1, ... The call ends in the idle cycle.
  task automatic rd_serve(input int who, input int n, input logic [31:0] d0, input bit rereq);
    r_arready = 1;
    @(negedge clk);
    chk("rd_grant", grant, (who == 1) ? 2'b10 : 2'b01);
    chk("rd_arready", arready_o[who], 1);
    next();
    arvalid[who] = 0; r_arready = 0; rready[who] = 1;
    for (int k = 0; k < n; k++) begin
      r_rvalid = 1; r_rdata = d0 + k; r_rlast = (k == n - 1);
      if (rereq && k == n - 1) arvalid[who] = 1;
      @(negedge clk); chk("rd_rdata", rdata_o[who], d0 + k);
      next();
    end
    r_rvalid = 0; r_rlast = 0; r_rdata = 0; rready[who] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 0;
    awvalid = 0; wready = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = 0; araddr[i] = 0; awlen[i] = 0; arlen[i] = 0; wdata[i] = 0;
    end
    r_awready = 0; r_wvalid = 0; r_wlast = 0; r_arready = 0; r_rvalid = 0; r_rlast = 0; r_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_timeout", timeout, 0);
    next(); rst_n = 1;
    next();

    // Single read by master 0.
    araddr[0] = 32'h100; arlen[0] = 1; arvalid[0] = 1;
    next();
    r_arready = 1;
    @(negedge clk);
    chk("t1_grant", grant, 2'b01); chk("t1_araddr", ram_araddr, 32'h100); chk("t1_arvalid", ram_arvalid, 1);
    next();
    arvalid[0] = 0; r_arready = 0; rready[0] = 1; r_rvalid = 1; r_rdata = 32'hDEADBEEF; r_rlast = 1;
    @(negedge clk);
    chk("t1_rdata", rdata_o[0], 32'hDEADBEEF); chk("t1_rvalid", rvalid_o[0], 1); chk("t1_m1_rvalid", rvalid_o[1], 0);
    next();
    r_rvalid = 0; r_rlast = 0; r_rdata = 0; rready[0] = 0;
    @(negedge clk); chk("t1_idle_grant", grant, 0); chk("t1_idle_busy", busy, 0);
    next();

    // Contention: both masters read. Master 1 re-requests, so both compete again.
    araddr[0] = 32'h300; araddr[1] = 32'h400; arlen[0] = 1; arlen[1] = 2; arvalid = 2'b11;
    next();
    @(negedge clk); chk("t2_first_grant", grant, 2'b10); chk("t2_m0_stalled", arready_o[0], 0);
    next();
    // The first loop pass re-runs the RD_ADDR cycle already checked above.
    rd_serve(1, 2, 32'hA000, 1);
    bubble();
    if (RR) begin
      rd_serve(0, 1, 32'hB000, 0);
      bubble();
      rd_serve(1, 1, 32'hC000, 0);
    end else begin
      rd_serve(1, 1, 32'hC000, 0);
      bubble();
      rd_serve(0, 1, 32'hB000, 0);
    end
    bubble();

    // Write and read from master 1 together: the write goes first.
    awaddr[1] = 32'h200; awlen[1] = 4; araddr[1] = 32'h240; arlen[1] = 4;
    awvalid[1] = 1; arvalid[1] = 1;
    next();
    r_awready = 1;
    @(negedge clk);
    chk("t3_awvalid", ram_awvalid, 1); chk("t3_arvalid", ram_arvalid, 0);
    chk("t3_awlen", ram_awlen, 4); chk("t3_awaddr", ram_awaddr, 32'h200);
    next();
    awvalid[1] = 0; r_awready = 0; wready[1] = 1; cnt = 0;
    for (int k = 0; k < 4; k++) begin
      wdata[1] = 32'hC0DE0000 + k; r_wvalid = 1; r_wlast = (k == 3);
      @(negedge clk);
      chk("t3_wdata", ram_wdata, 32'hC0DE0000 + k);
      if (ram_wready && r_wvalid) cnt++;
      next();
    end
    r_wvalid = 0; r_wlast = 0; wready[1] = 0;
    chk("t3_beats", cnt, 4);
    bubble();
    rd_serve(1, 1, 32'h55550000, 0);
    bubble();

    // Backpressure: RAM holds rvalid while master 0 is not ready.
    araddr[0] = 32'h500; arlen[0] = 1; arvalid[0] = 1;
    next();
    r_arready = 1;
    next();
    arvalid[0] = 0; r_arready = 0; rready[0] = 0; r_rvalid = 1; r_rdata = 32'h12345678; r_rlast = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_busy", busy, 1); chk("t4_rready", ram_rready, 0); chk("t4_rvalid", rvalid_o[0], 1);
      next();
    end
    rready[0] = 1;
    @(negedge clk); chk("t4_rready_up", ram_rready, 1); chk("t4_rdata", rdata_o[0], 32'h12345678);
    next();
    r_rvalid = 0; r_rlast = 0; r_rdata = 0; rready[0] = 0;
    bubble();

    // Reset during beat 2 of a 4-beat read.
    araddr[0] = 32'h600; arlen[0] = 4; arvalid[0] = 1;
    next();
    r_arready = 1;
    next();
    arvalid[0] = 0; r_arready = 0; rready[0] = 1; r_rvalid = 1; r_rdata = 32'h600; r_rlast = 0;
    @(negedge clk); chk("t5_beat1", rdata_o[0], 32'h600);
    next();
    r_rdata = 32'h601;
    #2 rst_n = 0;
    #1;
    chk("t5_rst_rvalid", rvalid_o[0], 0); chk("t5_rst_grant", grant, 0);
    chk("t5_rst_rready", ram_rready, 0); chk("t5_rst_rdata", rdata_o[0], 0); chk("t5_rst_busy", busy, 0);
    next();
    rst_n = 1; r_rdata = 32'h602;
    @(negedge clk); chk("t5_no_stale", rvalid_o[0], 0); chk("t5_idle", busy, 0);
    next();
    r_rvalid = 0; r_rdata = 0; rready[0] = 0;
    next();

    // Timeout: the address is never accepted.
    araddr[0] = 32'h700; arlen[0] = 1; arvalid[0] = 1; r_arready = 0;
    next();
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); chk("t6_wait_grant", grant, 2'b01); chk("t6_no_pulse", timeout, 0);
      next();
    end
    @(negedge clk); chk("t6_pulse", timeout, 1); chk("t6_idle", busy, 0);
    next();
    @(negedge clk); chk("t6_regrant", grant, 2'b01); chk("t6_pulse_gone", timeout, 0);
    next();
    arvalid[0] = 0;
    @(negedge clk); chk("t6_drop_arvalid", ram_arvalid, 0);
    next();
    @(negedge clk); chk("t6_drop_idle", busy, 0); chk("t6_drop_no_pulse", timeout, 0);
    next();
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
